mips_mc_controller: RTL and testbench

Multicycle control FSM that sequences the MIPS datapath (shared ALU, unified memory port, IR/A/B/ALUOut/MDR registers). It replaces the single-cycle combinational control unit so that one instruction takes 3-5 cycles and memory/ALU are reused across cycles. It sits beside the multicycle datapath, reads Opcode/Func from the instruction register and Zero from the ALU, and drives every enable and mux select.

---
 rtl/mips_mc_pkg.sv | 60 ++++++
 rtl/mips_alu_decoder.sv | 23 ++
 rtl/mips_mc_controller.sv | 174 +++++++++++++++++
 tb/tb_mips_mc_controller.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mc_pkg.sv
// Shared types and encodings for the multicycle MIPS control FSM.
package mips_mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11,
    S_JAL    = 4'd12,
    S_JR     = 4'd13
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_JR  = 6'b001000;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  localparam logic [1:0] RD_RT = 2'b00;
  localparam logic [1:0] RD_RD = 2'b01;
  localparam logic [1:0] RD_RA = 2'b10;

  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  localparam logic [1:0] SB_B     = 2'b00;
  localparam logic [1:0] SB_FOUR  = 2'b01;
  localparam logic [1:0] SB_IMM   = 2'b10;
  localparam logic [1:0] SB_IMMSH = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_REG    = 2'b11;

endpackage

// File: rtl/mips_alu_decoder.sv
// R-type funct decode: ALU operation plus a flag marking the funct as a supported ALU op.
module mips_alu_decoder
  import mips_mc_pkg::*;
(
  input  logic [5:0] func_i,
  output logic [3:0] alu_ctrl_o,
  output logic       legal_o
);

  always_comb begin
    alu_ctrl_o = ALU_ADD;
    legal_o    = 1'b1;
    case (func_i)
      FN_ADD:  alu_ctrl_o = ALU_ADD;
      FN_SUB:  alu_ctrl_o = ALU_SUB;
      FN_AND:  alu_ctrl_o = ALU_AND;
      FN_OR:   alu_ctrl_o = ALU_OR;
      FN_SLT:  alu_ctrl_o = ALU_SLT;
      default: legal_o    = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_mc_controller.sv
// Multicycle MIPS control FSM: sequences the shared ALU, memory port and datapath registers.
module mips_mc_controller
  import mips_mc_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       Opcode,
  input  logic [5:0]       Func,
  input  logic             Zero,
  output logic             PCEn,
  output logic             IorD,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic [1:0]       RegDst,
  output logic [1:0]       MemtoReg,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [3:0]       ALUControl,
  output logic [1:0]       PCSrc,
  output logic             Illegal,
  output logic [3:0]       State,
  output logic [CNT_W-1:0] RetireCount
);

  state_e             state_q, state_d;
  state_e             decode_tgt;
  logic [CNT_W-1:0]   retire_q;
  logic [3:0]         fn_ctrl;
  logic               fn_legal;
  logic               op_legal;
  logic               terminal;

  mips_alu_decoder u_alu_dec (
    .func_i     (Func),
    .alu_ctrl_o (fn_ctrl),
    .legal_o    (fn_legal)
  );

  always_comb begin
    decode_tgt = S_FETCH;
    op_legal   = 1'b1;
    case (Opcode)
      OP_LW, OP_SW: decode_tgt = S_MEMADR;
      OP_RTYPE: begin
        if (Func == FN_JR)  decode_tgt = S_JR;
        else if (fn_legal)  decode_tgt = S_EXEC;
        else                op_legal   = 1'b0;
      end
      OP_BEQ:  decode_tgt = S_BRANCH;
      OP_ADDI: decode_tgt = S_ADDIEX;
      OP_J:    decode_tgt = S_JUMP;
      OP_JAL:  decode_tgt = S_JAL;
      default: op_legal   = 1'b0;
    endcase
  end

  assign terminal = state_q inside {S_MEMWB, S_MEMWR, S_ALUWB, S_BRANCH,
                                    S_ADDIWB, S_JUMP, S_JAL, S_JR};

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = decode_tgt;
      S_MEMADR: begin
        if (Opcode == OP_LW)      state_d = S_MEMRD;
        else if (Opcode == OP_SW) state_d = S_MEMWR;
        else                      state_d = S_FETCH;
      end
      S_MEMRD:  state_d = S_MEMWB;
      S_EXEC:   state_d = S_ALUWB;
      S_ADDIEX: state_d = S_ADDIWB;
      default:  state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_FETCH;
      retire_q <= '0;
    end else begin
      state_q <= state_d;
      if (terminal) retire_q <= retire_q + CNT_W'(1);
    end
  end

  always_comb begin
    PCEn       = 1'b0;
    IorD       = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegDst     = RD_RT;
    MemtoReg   = M2R_ALUOUT;
    RegWrite   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = SB_B;
    ALUControl = ALU_AND;
    PCSrc      = PC_ALU;
    Illegal    = 1'b0;
    case (state_q)
      S_FETCH: begin
        IRWrite    = 1'b1;
        ALUSrcB    = SB_FOUR;
        ALUControl = ALU_ADD;
        PCEn       = 1'b1;
      end
      S_DECODE: begin
        ALUSrcB    = SB_IMMSH;
        ALUControl = ALU_ADD;
        Illegal    = ~op_legal;
      end
      S_MEMADR, S_ADDIEX: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = SB_IMM;
        ALUControl = ALU_ADD;
      end
      S_MEMRD: IorD = 1'b1;
      S_MEMWB: begin
        MemtoReg = M2R_MDR;
        RegWrite = 1'b1;
      end
      S_MEMWR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA    = 1'b1;
        ALUControl = fn_ctrl;
      end
      S_ALUWB: begin
        RegDst   = RD_RD;
        RegWrite = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUControl = ALU_SUB;
        PCSrc      = PC_ALUOUT;
        PCEn       = Zero;
      end
      S_ADDIWB: RegWrite = 1'b1;
      S_JUMP: begin
        PCSrc = PC_JUMP;
        PCEn  = 1'b1;
      end
      S_JAL: begin
        PCSrc    = PC_JUMP;
        PCEn     = 1'b1;
        RegDst   = RD_RA;
        MemtoReg = M2R_PC;
        RegWrite = 1'b1;
      end
      S_JR: begin
        PCSrc = PC_REG;
        PCEn  = 1'b1;
      end
      default: ;
    endcase
    // Reset must suppress every side-effecting strobe even though state_q still holds the abandoned state.
    if (reset) begin
      PCEn     = 1'b0;
      IRWrite  = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
      Illegal  = 1'b0;
    end
  end

  assign State       = state_q;
  assign RetireCount = retire_q;

endmodule

// File: tb/tb_mips_mc_controller.sv
// Randomized self-checking bench for mips_mc_controller against an instruction-level model.
module tb_mips_mc_controller;

  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [5:0]    Opcode, Func;
  logic          Zero;
  logic          PCEn, IorD, MemWrite, IRWrite, RegWrite, ALUSrcA, Illegal;
  logic [1:0]    RegDst, MemtoReg, ALUSrcB, PCSrc;
  logic [3:0]    ALUControl, State;
  logic [CW-1:0] RetireCount;

  mips_mc_controller #(.CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .Func(Func), .Zero(Zero),
    .PCEn(PCEn), .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
    .PCSrc(PCSrc), .Illegal(Illegal), .State(State), .RetireCount(RetireCount)
  );

  always #5 clk = ~clk;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int unsigned mcount = 0;

  // Packed cycle vector: {state, pcen, iord, memwrite, irwrite, regdst, memtoreg,
  //                       regwrite, alusrca, alusrcb, aluctrl, pcsrc, illegal}
  logic [22:0] tab [0:13];
  logic [22:0] obs_q[$];
  logic        zobs_q[$];
  int          seq_q[$];
  logic [5:0]  legal_ops [0:9];
  logic [5:0]  legal_fns [0:9];

  function automatic logic [22:0] pk(input logic [3:0] st, input logic pcen, iord, mw, irw,
                                     input logic [1:0] rd, mtr, input logic rw, sa,
                                     input logic [1:0] sb, input logic [3:0] ac,
                                     input logic [1:0] ps, input logic ill);
    return {st, pcen, iord, mw, irw, rd, mtr, rw, sa, sb, ac, ps, ill};
  endfunction

  function automatic logic [22:0] ov();
    return {State, PCEn, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
            ALUSrcA, ALUSrcB, ALUControl, PCSrc, Illegal};
  endfunction

  function automatic logic [3:0] alu_of(input logic [5:0] fn);
    case (fn)
      6'b100000: return 4'b0010;
      6'b100010: return 4'b0110;
      6'b100100: return 4'b0000;
      6'b100101: return 4'b0001;
      default:   return 4'b0111;
    endcase
  endfunction

  // State walk an instruction takes; returns 0 for an unsupported encoding.
  function automatic bit build_seq(input logic [5:0] op, input logic [5:0] fn);
    seq_q = {0, 1};
    case (op)
      6'b100011: seq_q = {0, 1, 2, 3, 4};
      6'b101011: seq_q = {0, 1, 2, 5};
      6'b000100: seq_q = {0, 1, 8};
      6'b001000: seq_q = {0, 1, 9, 10};
      6'b000010: seq_q = {0, 1, 11};
      6'b000011: seq_q = {0, 1, 12};
      6'b000000: begin
        if (fn == 6'b001000) seq_q = {0, 1, 13};
        else if (fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010})
          seq_q = {0, 1, 6, 7};
        else return 1'b0;
      end
      default: return 1'b0;
    endcase
    return 1'b1;
  endfunction

  // zmode: 0 random Zero, 1 force Zero=1, 2 force Zero=0.
  task automatic test_instruction(input logic [5:0] op, input logic [5:0] fn, input int zmode);
    bit          legal, done;
    logic [22:0] e;
    obs_q.delete();
    zobs_q.delete();
    Opcode = op;
    Func   = fn;
    Zero   = (zmode == 0) ? 1'($urandom_range(0, 1)) : (zmode == 1);
    #1;
    obs_q.push_back(ov());
    zobs_q.push_back(Zero);
    done = 1'b0;
    for (int c = 0; c < 8 && !done; c++) begin
      @(posedge clk); #1;
      Zero = (zmode == 0) ? 1'($urandom_range(0, 1)) : (zmode == 1);
      #1;
      if (State == 4'd0) done = 1'b1;
      else begin
        obs_q.push_back(ov());
        zobs_q.push_back(Zero);
      end
    end
    legal = build_seq(op, fn);
    vectors++;
    if (!done || obs_q.size() != seq_q.size()) begin
      miscompares++;
      $display("FAIL latency op=%b fn=%b: got %0d cycles (returned=%0d), want %0d",
               op, fn, obs_q.size(), done, seq_q.size());
    end else begin
      for (int i = 0; i < seq_q.size(); i++) begin
        e = tab[seq_q[i]];
        if (seq_q[i] == 6) e[6:3] = alu_of(fn);
        if (seq_q[i] == 1) e[0] = ~legal;
        if (seq_q[i] == 8) e[18] = zobs_q[i];
        vectors++;
        if (obs_q[i] !== e) begin
          miscompares++;
          $display("FAIL cycle%0d op=%b fn=%b: got %h, want %h", i, op, fn, obs_q[i], e);
        end
      end
    end
    if (legal) mcount = (mcount + 1) % (1 << CW);
    vectors++;
    if (RetireCount !== CW'(mcount)) begin
      miscompares++;
      $display("FAIL retire op=%b: got %0d, want %0d", op, RetireCount, mcount);
    end
  endtask

  task automatic do_reset(input int cycles);
    reset  = 1'b1;
    Opcode = 6'($urandom);
    Func   = 6'($urandom);
    Zero   = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
    mcount = 0;
  endtask

  task automatic test_reset();
    do_reset(2);
    vectors++;
    if (State !== 4'd0 || RetireCount !== '0) begin
      miscompares++;
      $display("FAIL reset_state: got state=%0d cnt=%0d, want 0/0", State, RetireCount);
    end
    vectors++;
    if ({PCEn, IRWrite, MemWrite, RegWrite, Illegal} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_strobes: got %b, want 00000",
               {PCEn, IRWrite, MemWrite, RegWrite, Illegal});
    end
    reset = 1'b0;
    #1;
  endtask

  task automatic test_directed();
    test_instruction(6'b100011, 6'($urandom), 0);
    test_instruction(6'b101011, 6'($urandom), 0);
    test_instruction(6'b000000, 6'b101010, 0);
    test_instruction(6'b000000, 6'b001000, 0);
    test_instruction(6'b000100, 6'($urandom), 1);
    test_instruction(6'b000100, 6'($urandom), 2);
    test_instruction(6'b000011, 6'($urandom), 0);
    test_instruction(6'b111111, 6'($urandom), 0);
    test_instruction(6'b000000, 6'b000000, 0);
  endtask

  task automatic test_reset_mid();
    Opcode = 6'b100011;
    Func   = 6'($urandom);
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (State !== 4'd3) begin
      miscompares++;
      $display("FAIL mid_in_memrd: got state=%0d, want 3", State);
    end
    reset = 1'b1;
    #1;
    vectors++;
    if ({PCEn, IRWrite, MemWrite, RegWrite, Illegal} !== 5'b0) begin
      miscompares++;
      $display("FAIL mid_strobes: got %b, want 00000",
               {PCEn, IRWrite, MemWrite, RegWrite, Illegal});
    end
    @(posedge clk); #1;
    mcount = 0;
    vectors++;
    if (State !== 4'd0 || RetireCount !== '0) begin
      miscompares++;
      $display("FAIL mid_after: got state=%0d cnt=%0d, want 0/0", State, RetireCount);
    end
    reset  = 1'b0;
    Opcode = 6'b111111;
    #1;
    for (int c = 0; c < 3; c++) begin
      vectors++;
      if (RegWrite !== 1'b0) begin
        miscompares++;
        $display("FAIL mid_no_write c%0d: got RegWrite=%b, want 0", c, RegWrite);
      end
      if (c < 2) begin @(posedge clk); #2; end
    end
    vectors++;
    if (State !== 4'd0 || RetireCount !== '0) begin
      miscompares++;
      $display("FAIL mid_resume: got state=%0d cnt=%0d, want 0/0", State, RetireCount);
    end
  endtask

  task automatic test_wrap();
    int k;
    do_reset(1);
    reset = 1'b0;
    #1;
    for (int n = 0; n < 15; n++) begin
      k = $urandom_range(0, 9);
      test_instruction(legal_ops[k], legal_fns[k], 0);
    end
    vectors++;
    if (RetireCount !== CW'(15)) begin
      miscompares++;
      $display("FAIL wrap_max: got %0d, want 15", RetireCount);
    end
    test_instruction(6'b000010, 6'($urandom), 0);
    vectors++;
    if (RetireCount !== '0) begin
      miscompares++;
      $display("FAIL wrap_zero: got %0d, want 0", RetireCount);
    end
  endtask

  task automatic test_random();
    int k;
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 9) < 7) begin
        k = $urandom_range(0, 9);
        test_instruction(legal_ops[k],
                         (legal_ops[k] == 6'b000000) ? legal_fns[k] : 6'($urandom), 0);
      end else begin
        test_instruction(6'($urandom), 6'($urandom), 0);
      end
    end
  endtask

  initial begin
    tab[0]  = pk(4'd0,  1,0,0,1, 2'b00,2'b00, 0,0, 2'b01, 4'b0010, 2'b00, 0);
    tab[1]  = pk(4'd1,  0,0,0,0, 2'b00,2'b00, 0,0, 2'b11, 4'b0010, 2'b00, 0);
    tab[2]  = pk(4'd2,  0,0,0,0, 2'b00,2'b00, 0,1, 2'b10, 4'b0010, 2'b00, 0);
    tab[3]  = pk(4'd3,  0,1,0,0, 2'b00,2'b00, 0,0, 2'b00, 4'b0000, 2'b00, 0);
    tab[4]  = pk(4'd4,  0,0,0,0, 2'b00,2'b01, 1,0, 2'b00, 4'b0000, 2'b00, 0);
    tab[5]  = pk(4'd5,  0,1,1,0, 2'b00,2'b00, 0,0, 2'b00, 4'b0000, 2'b00, 0);
    tab[6]  = pk(4'd6,  0,0,0,0, 2'b00,2'b00, 0,1, 2'b00, 4'b0000, 2'b00, 0);
    tab[7]  = pk(4'd7,  0,0,0,0, 2'b01,2'b00, 1,0, 2'b00, 4'b0000, 2'b00, 0);
    tab[8]  = pk(4'd8,  0,0,0,0, 2'b00,2'b00, 0,1, 2'b00, 4'b0110, 2'b01, 0);
    tab[9]  = pk(4'd9,  0,0,0,0, 2'b00,2'b00, 0,1, 2'b10, 4'b0010, 2'b00, 0);
    tab[10] = pk(4'd10, 0,0,0,0, 2'b00,2'b00, 1,0, 2'b00, 4'b0000, 2'b00, 0);
    tab[11] = pk(4'd11, 1,0,0,0, 2'b00,2'b00, 0,0, 2'b00, 4'b0000, 2'b10, 0);
    tab[12] = pk(4'd12, 1,0,0,0, 2'b10,2'b10, 1,0, 2'b00, 4'b0000, 2'b10, 0);
    tab[13] = pk(4'd13, 1,0,0,0, 2'b00,2'b00, 0,0, 2'b00, 4'b0000, 2'b11, 0);
    legal_ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000000, 6'b000000,
                  6'b000000, 6'b000000, 6'b000000, 6'b000100, 6'b001000};
    legal_fns = '{6'b000000, 6'b000000, 6'b100000, 6'b100010, 6'b100100,
                  6'b100101, 6'b101010, 6'b001000, 6'b000000, 6'b000000};
    test_reset();
    test_directed();
    test_reset_mid();
    test_wrap();
    test_random();
    test_instruction(6'b000011, 6'($urandom), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
